// File: rtl/rr_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : rr_arb_pkg
// Purpose  : Shared state encoding and width helpers for the packet arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Never returns less than 1 so single-value ranges still get a real bit.
  function automatic int clog2_safe(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  // Beat counter must hold 0..MAX_BEATS inclusive.
  function automatic int beat_cnt_width(input int max_beats);
    return clog2_safe(max_beats + 1);
  endfunction

  localparam int DEF_N         = 4;
  localparam int DEF_W         = 32;
  localparam int DEF_MAX_BEATS = 16;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//------------------------------------------------------------------------------
// Module   : rr_pick
// Purpose  : Combinational rotate-priority one-hot picker (double-width mask).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]               req,
  input  logic [clog2_safe(N)-1:0]   ptr,
  output logic [N-1:0]               gnt_onehot,
  output logic [clog2_safe(N)-1:0]   gnt_id,
  output logic                       any
);

  localparam int PW = clog2_safe(N);

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;
  logic [PW:0]    w_idx;

  // Lower half keeps only requesters at or above ptr; upper half wraps around.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (PW'(i) >= ptr);
    end
    w_dbl = {req, req & w_mask};

    w_idx = '0;
    for (int k = 2*N-1; k >= 0; k--) begin
      if (w_dbl[k]) w_idx = (PW+1)'(k);
    end

    if (w_idx >= (PW+1)'(N)) gnt_id = PW'(w_idx - (PW+1)'(N));
    else                     gnt_id = PW'(w_idx);

    any = |req;

    gnt_onehot = '0;
    for (int i = 0; i < N; i++) begin
      gnt_onehot[i] = any && (gnt_id == PW'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_pkt_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_pkt_arbiter
// Purpose  : Packet-level round-robin arbiter with beat watchdog on a shared
//            valid/ready channel.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pkt_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int W         = DEF_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req_valid,
  input  logic [N*W-1:0]           req_data,
  input  logic [N-1:0]             req_last,
  output logic [N-1:0]             req_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [N-1:0]             grant,
  output logic [clog2_safe(N)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_pulse
);

  localparam int PW = clog2_safe(N);
  localparam int CW = beat_cnt_width(MAX_BEATS);

  arb_state_e      r_state,    w_state_nxt;
  logic [PW-1:0]   r_ptr,      w_ptr_nxt;
  logic [PW-1:0]   r_grant_id, w_grant_id_nxt;
  logic [N-1:0]    r_grant,    w_grant_nxt;
  logic [CW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic            r_timeout,  w_timeout_nxt;

  logic [N-1:0]    w_pick_onehot;
  logic [PW-1:0]   w_pick_id;
  logic            w_pick_any;

  logic            w_sel_valid;
  logic            w_sel_last;
  logic [W-1:0]    w_sel_data;
  logic            w_accept;

  rr_pick #(.N(N)) u_pick (
    .req        (req_valid),
    .ptr        (r_ptr),
    .gnt_onehot (w_pick_onehot),
    .gnt_id     (w_pick_id),
    .any        (w_pick_any)
  );

  // Grant is all-zero in IDLE, so the mux naturally yields zeros there.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[i*W +: W];
      end
    end
  end

  assign w_accept      = (r_state == BUSY) && w_sel_valid && out_ready;

  assign out_valid     = w_sel_valid;
  assign out_data      = w_sel_data;
  assign out_last      = w_sel_last;
  assign req_ready     = r_grant & {N{out_ready}};
  assign grant         = r_grant;
  assign grant_id      = r_grant_id;
  assign busy          = (r_state == BUSY);
  assign timeout_pulse = r_timeout;

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_id_nxt = r_grant_id;
    w_grant_nxt    = r_grant;
    w_beat_cnt_nxt = r_beat_cnt;
    w_timeout_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt    = BUSY;
          w_grant_nxt    = w_pick_onehot;
          w_grant_id_nxt = w_pick_id;
          w_beat_cnt_nxt = '0;
        end
      end
      BUSY: begin
        if (w_accept) begin
          // Watchdog counts accepted beats only; a stalled owner keeps the lock.
          if (w_sel_last || (r_beat_cnt == CW'(MAX_BEATS - 1))) begin
            w_state_nxt    = IDLE;
            w_grant_nxt    = '0;
            w_grant_id_nxt = '0;
            w_beat_cnt_nxt = '0;
            w_ptr_nxt      = (r_grant_id == PW'(N - 1)) ? '0 : r_grant_id + PW'(1);
            w_timeout_nxt  = !w_sel_last;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_grant    <= w_grant_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

endmodule

`default_nettype wire
